fifo_rd_stream: RTL and testbench

Read-side controller for the asynchronous FIFO, in the read clock domain. It consumes the write pointer after synchronization, computes empty and fill level, and drives the dual-port memory read port. It also hides the memory's one-cycle read latency behind a 3-entry output buffer, so consumers see a valid/ready stream. The registered Gray read pointer it returns is synchronized back into the write domain for the full calculation.

---
 rtl/fifo_rd_stream_if.sv | 34 +++
 rtl/fifo_rd_stream.sv | 68 ++++++
 tb/tb_fifo_rd_stream.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: read-domain bundle of the async FIFO reader (pointer exchange, memory read port, output stream)
// Ports carried:
//   wr_ptr_gray_sync_i  synchronized Gray write pointer (into controller)
//   rd_ptr_gray_o       registered Gray read pointer (out to write-domain synchronizer)
//   rd_empty_o          no unfetched entries in memory
//   rd_level_o          unfetched entry count (0..depth)
//   rd_en_o, rd_addr_o  memory read strobe and address
//   rd_data_i           memory read data, one cycle after rd_en_o
//   m_valid_o, m_data_o, m_ready_i  output valid/ready stream
interface fifo_rd_stream_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
);
    logic [ADDR_WIDTH:0]   wr_ptr_gray_sync_i;
    logic [ADDR_WIDTH:0]   rd_ptr_gray_o;
    logic                  rd_empty_o;
    logic [ADDR_WIDTH:0]   rd_level_o;
    logic                  rd_en_o;
    logic [ADDR_WIDTH-1:0] rd_addr_o;
    logic [DATA_WIDTH-1:0] rd_data_i;
    logic                  m_valid_o;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic                  m_ready_i;

    modport master (
        input  wr_ptr_gray_sync_i, rd_data_i, m_ready_i,
        output rd_ptr_gray_o, rd_empty_o, rd_level_o, rd_en_o, rd_addr_o, m_valid_o, m_data_o
    );

    modport slave (
        output wr_ptr_gray_sync_i, rd_data_i, m_ready_i,
        input  rd_ptr_gray_o, rd_empty_o, rd_level_o, rd_en_o, rd_addr_o, m_valid_o, m_data_o
    );
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: async FIFO read-side controller with 3-entry output buffer hiding memory read latency
// Ports:
//   clk_rd_i  read-domain clock
//   rst_i     asynchronous active-high reset
//   bus       fifo_rd_stream_if.master: pointer exchange, empty/level status,
//             memory read port and the valid/ready output stream
module fifo_rd_stream #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 128,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk_rd_i,
    input  logic                  rst_i,
    fifo_rd_stream_if.master      bus
);
    localparam int PW = ADDR_WIDTH + 1;

    logic [PW-1:0]         rd_ptr_bin, rd_ptr_gray, rd_ptr_nxt, wr_bin;
    logic [1:0]            occ, occ_nxt, head, head_nxt, tail;
    logic [2:0]            head_plus_occ;
    logic                  inflight, push, pop, rd_en, rd_empty;
    logic [DATA_WIDTH-1:0] buf_q [3];

    always_comb begin
        wr_bin = '0;
        for (int i = 0; i < PW; i++) wr_bin[i] = ^(bus.wr_ptr_gray_sync_i >> i);
    end

    assign rd_empty = (rd_ptr_gray == bus.wr_ptr_gray_sync_i);
    // Budget uses only registered occupancy terms so m_ready_i never reaches rd_en; gated during reset so no read is issued while held
    assign rd_en         = !rst_i && !rd_empty && (({1'b0, occ} + {2'b0, inflight}) < 3'd3);
    assign rd_ptr_nxt    = rd_ptr_bin + 1'b1;
    assign push          = inflight;
    assign pop           = (occ != 2'd0) && bus.m_ready_i;
    assign occ_nxt       = occ + {1'b0, push} - {1'b0, pop};
    assign head_nxt      = pop ? ((head == 2'd2) ? 2'd0 : head + 2'd1) : head;
    // Tail slot is taken before any same-cycle pop, which is safe because push implies occ <= 2
    assign head_plus_occ = {1'b0, head} + {1'b0, occ};
    assign tail          = (head_plus_occ >= 3'd3) ? 2'(head_plus_occ - 3'd3) : head_plus_occ[1:0];

    always_ff @(posedge clk_rd_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_bin  <= '0;
            rd_ptr_gray <= '0;
            occ         <= '0;
            head        <= '0;
            inflight    <= 1'b0;
            buf_q       <= '{default: '0};
        end else begin
            if (rd_en) begin
                rd_ptr_bin  <= rd_ptr_nxt;
                rd_ptr_gray <= rd_ptr_nxt ^ (rd_ptr_nxt >> 1);
            end
            inflight <= rd_en;
            occ      <= occ_nxt;
            head     <= head_nxt;
            if (push) buf_q[tail] <= bus.rd_data_i;
        end
    end

    assign bus.rd_ptr_gray_o = rd_ptr_gray;
    assign bus.rd_empty_o    = rd_empty;
    assign bus.rd_level_o    = wr_bin - rd_ptr_bin;
    assign bus.rd_en_o       = rd_en;
    assign bus.rd_addr_o     = rd_ptr_bin[ADDR_WIDTH-1:0];
    assign bus.m_valid_o     = (occ != 2'd0);
    assign bus.m_data_o      = buf_q[head];
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: table vectors, corner sequences and a randomized scoreboard for fifo_rd_stream
module tb_fifo_rd_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_rd_stream_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) bus ();
    fifo_rd_stream #(.DATA_WIDTH(16), .FIFO_DEPTH(8)) dut (.clk_rd_i(clk), .rst_i(rst), .bus(bus));

    logic [15:0] mem [8];
    always @(posedge clk) if (bus.rd_en_o) bus.rd_data_i <= mem[bus.rd_addr_o];

    typedef struct {
        logic [3:0]  wr_gray;
        logic        rdy;
        logic        en;
        logic [2:0]  addr;
        logic        valid;
        logic [15:0] data;
        logic        empty;
        logic [3:0]  level;
        logic [3:0]  gray;
    } vec_t;

    int compared = 0, mismatched = 0;
    int wr_cnt, fetch_cnt, pop_cnt, wraps, msb_flips;
    logic [2:0]  last_addr;
    logic [3:0]  prev_gray;
    logic [15:0] exp_q [$];
    vec_t        vecs [7];

    function automatic logic [3:0] gray(input int n);
        logic [3:0] b;
        b = n[3:0];
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic model_reset();
        wr_cnt = 0; fetch_cnt = 0; pop_cnt = 0; wraps = 0; msb_flips = 0;
        last_addr = 3'd0; prev_gray = 4'd0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wr_ptr_gray_sync_i = 4'd0;
        bus.m_ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] v);
        mem[wr_cnt % 8] = v;
        exp_q.push_back(v);
        wr_cnt++;
        bus.wr_ptr_gray_sync_i = gray(wr_cnt);
    endtask

    task automatic cycle_checks();
        check("level", bus.rd_level_o, 32'((wr_cnt - fetch_cnt) & 15));
        check("empty", bus.rd_empty_o, 32'(wr_cnt == fetch_cnt));
        check("rd_gray", bus.rd_ptr_gray_o, gray(fetch_cnt));
        check("rd_en_while_empty", bus.rd_en_o & bus.rd_empty_o, 0);
        check("occ_bound", 32'((fetch_cnt - pop_cnt) <= 3), 1);
        check("gray_one_bit", 32'($countones(bus.rd_ptr_gray_o ^ prev_gray) <= 1), 1);
        if (bus.rd_ptr_gray_o[3] != prev_gray[3]) msb_flips++;
        prev_gray = bus.rd_ptr_gray_o;
        if (bus.m_valid_o && bus.m_ready_i) begin
            if (exp_q.size() == 0) check("extra_beat", bus.m_valid_o, 0);
            else check("beat_data", bus.m_data_o, exp_q.pop_front());
            pop_cnt++;
        end
        if (bus.rd_en_o) begin
            check("rd_addr", bus.rd_addr_o, 32'(fetch_cnt % 8));
            if (bus.rd_addr_o == 3'd0 && last_addr == 3'd7) wraps++;
            last_addr = bus.rd_addr_o;
            fetch_cnt++;
        end
    endtask

    task automatic stream(input int n_pop, input int n_wr, input int rdy_pct, input int wr_pct, input int budget);
        int target, left, cyc;
        target = pop_cnt + n_pop;
        left = n_wr;
        cyc = 0;
        while (pop_cnt < target && cyc < budget) begin
            @(negedge clk);
            cyc++;
            bus.m_ready_i = ($urandom_range(99) < rdy_pct);
            if (left > 0 && wr_cnt - pop_cnt < 8 && $urandom_range(99) < wr_pct) begin
                do_write(16'($urandom));
                left--;
            end
            #1 cycle_checks();
        end
        check("words_done", pop_cnt, target);
    endtask

    initial begin
        bus.wr_ptr_gray_sync_i = 4'd0;
        bus.m_ready_i = 1'b0;
        model_reset();
        vecs[0] = '{4'b0110, 1'b1, 1'b1, 3'd0, 1'b0, 16'h0000, 1'b0, 4'd4, 4'b0000};
        vecs[1] = '{4'b0110, 1'b1, 1'b1, 3'd1, 1'b0, 16'h0000, 1'b0, 4'd3, 4'b0001};
        vecs[2] = '{4'b0110, 1'b1, 1'b1, 3'd2, 1'b1, 16'h1111, 1'b0, 4'd2, 4'b0011};
        vecs[3] = '{4'b0110, 1'b1, 1'b1, 3'd3, 1'b1, 16'h2222, 1'b0, 4'd1, 4'b0010};
        vecs[4] = '{4'b0110, 1'b1, 1'b0, 3'd0, 1'b1, 16'h3333, 1'b1, 4'd0, 4'b0110};
        vecs[5] = '{4'b0110, 1'b1, 1'b0, 3'd0, 1'b1, 16'h4444, 1'b1, 4'd0, 4'b0110};
        vecs[6] = '{4'b0110, 1'b1, 1'b0, 3'd0, 1'b0, 16'h0000, 1'b1, 4'd0, 4'b0110};

        repeat (2) @(negedge clk);
        #1;
        check("rst_gray", bus.rd_ptr_gray_o, 0);
        check("rst_rd_en", bus.rd_en_o, 0);
        check("rst_addr", bus.rd_addr_o, 0);
        check("rst_valid", bus.m_valid_o, 0);
        check("rst_data", bus.m_data_o, 0);
        check("rst_empty", bus.rd_empty_o, 1);
        check("rst_level", bus.rd_level_o, 0);
        rst = 1'b0;

        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.wr_ptr_gray_sync_i = vecs[i].wr_gray;
            bus.m_ready_i = vecs[i].rdy;
            #1;
            check($sformatf("burst%0d_en", i), bus.rd_en_o, vecs[i].en);
            if (vecs[i].en) check($sformatf("burst%0d_addr", i), bus.rd_addr_o, vecs[i].addr);
            check($sformatf("burst%0d_valid", i), bus.m_valid_o, vecs[i].valid);
            if (vecs[i].valid) check($sformatf("burst%0d_data", i), bus.m_data_o, vecs[i].data);
            check($sformatf("burst%0d_empty", i), bus.rd_empty_o, vecs[i].empty);
            check($sformatf("burst%0d_level", i), bus.rd_level_o, vecs[i].level);
            check($sformatf("burst%0d_gray", i), bus.rd_ptr_gray_o, vecs[i].gray);
        end

        do_reset();
        @(negedge clk);
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) do_write(16'($urandom));
        #1;
        check("bp_level_full", bus.rd_level_o, 8);
        cycle_checks();
        repeat (10) begin
            @(negedge clk);
            #1 cycle_checks();
        end
        check("bp_fetches", fetch_cnt, 3);
        check("bp_level", bus.rd_level_o, 5);
        check("bp_valid", bus.m_valid_o, 1);
        check("bp_head", bus.m_data_o, exp_q[0]);
        stream(8, 0, 100, 0, 60);
        repeat (5) begin
            @(negedge clk);
            bus.m_ready_i = 1'b1;
            #1 cycle_checks();
        end
        check("bp_drained", exp_q.size(), 0);

        do_reset();
        @(negedge clk);
        bus.m_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) do_write(16'($urandom));
        #1 cycle_checks();
        repeat (4) begin
            @(negedge clk);
            #1 cycle_checks();
        end
        check("mid_valid_before", bus.m_valid_o, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_valid", bus.m_valid_o, 0);
        check("mid_gray", bus.rd_ptr_gray_o, 0);
        check("mid_addr", bus.rd_addr_o, 0);
        check("mid_rd_en", bus.rd_en_o, 0);
        check("mid_data", bus.m_data_o, 0);
        check("mid_level", bus.rd_level_o, 8);
        do_reset();

        stream(20, 20, 100, 100, 200);
        check("wrap_count", wraps, 2);
        check("gray_msb_flips", msb_flips, 2);

        do_reset();
        stream(1000, 1000, 50, 60, 20000);
        check("rand_left", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
